// File: rtl/simon_pkg.sv
// Shared constants, types and colour-scaling helper for the Simon button screen.
package simon_pkg;

  localparam int          LVL_W   = 4;
  localparam logic [3:0]  LVL_MAX = 4'd15;
  localparam int          LATENCY = 4;

  typedef enum logic [1:0] {
    Q_B = 2'd0,
    Q_Y = 2'd1,
    Q_R = 2'd2,
    Q_G = 2'd3
  } quad_e;

  // Index 0 = B, 1 = Y, 2 = R, 3 = G
  localparam logic [3:0][23:0] COLOR = {24'h00FF00, 24'hFF0000, 24'hFFFF00, 24'h0000FF};

  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [LVL_W-1:0] l);
    logic [11:0] prod;
    prod = 12'(c) * (12'(l) + 12'd1);
    return prod[11:4];
  endfunction

  function automatic logic [23:0] scale_rgb(input logic [23:0] c, input logic [LVL_W-1:0] l);
    return {scale_ch(c[23:16], l), scale_ch(c[15:8], l), scale_ch(c[7:0], l)};
  endfunction

endpackage

// File: rtl/simon_fade_ctrl.sv
// Per-button brightness counters stepped once per frame; lvl exposes the post-update value
// so a pixel coinciding with frame_start already sees the new level.
module simon_fade_ctrl
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic [3:0]  btn_on,
  output logic [15:0] lvl
);

  logic [3:0][LVL_W-1:0] lvl_q, lvl_d;

  always_comb begin
    lvl_d = lvl_q;
    if (frame_start) begin
      for (int i = 0; i < 4; i++) begin
        if (btn_on[i]) begin
          lvl_d[i] = LVL_MAX;
        end else if (lvl_q[i] == 4'd0) begin
          lvl_d[i] = 4'd0;
        end else begin
          lvl_d[i] = lvl_q[i] - 4'd1;
        end
      end
    end else begin
      lvl_d = lvl_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q <= '0;
    end else begin
      lvl_q <= lvl_d;
    end
  end

  assign lvl = lvl_d;

endmodule

// File: rtl/simon_pixel_pipe.sv
// Four-stage pixel pipeline drawing four annular quarter-circle buttons with a cross gap,
// each tinted by its frame-synchronous brightness level.
module simon_pixel_pipe
  import simon_pkg::*;
#(
  parameter int          COORD_W  = 16,
  parameter int          CENTER_X = 1100,
  parameter int          CENTER_Y = 562,
  parameter int          R_OUTER  = 300,
  parameter int          R_INNER  = 60,
  parameter int          GAP      = 8,
  parameter logic [23:0] BG_COLOR = 24'h101010
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               vde,
  input  logic               frame_start,
  input  logic [3:0]         btn_on,
  output logic [7:0]         R,
  output logic [7:0]         G,
  output logic [7:0]         B,
  output logic               vde_out
);

  localparam int PW = 2 * COORD_W + 2;
  localparam logic signed [COORD_W:0] CX_S  = (COORD_W + 1)'(CENTER_X);
  localparam logic signed [COORD_W:0] CY_S  = (COORD_W + 1)'(CENTER_Y);
  localparam logic signed [COORD_W:0] GAP_S = (COORD_W + 1)'(GAP);
  localparam logic [PW:0] R_IN2  = (PW + 1)'(R_INNER * R_INNER);
  localparam logic [PW:0] R_OUT2 = (PW + 1)'(R_OUTER * R_OUTER);

  logic [15:0] lvl_s;

  simon_fade_ctrl u_fade (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .btn_on      (btn_on),
    .lvl         (lvl_s)
  );

  logic signed [COORD_W:0] dx_q, dy_q;
  logic                    vde1_q, vde2_q, vde3_q, vde_out_q;
  logic [15:0]             lvl1_q, lvl2_q, lvl3_q;
  logic [PW-1:0]           dx2_q, dy2_q;
  logic                    dxn_q, dyn_q, gapx_q, gapy_q, hit_q;
  quad_e                   quad_q, quad_d;
  logic [23:0]             rgb_q, rgb_d;

  logic signed [COORD_W:0] dx_d, dy_d;
  logic signed [PW-1:0]    dx_sq_s, dy_sq_s;
  logic [PW:0]             d2_s;
  logic                    hit_d;
  logic [LVL_W-1:0]        lvl_sel_s;

  assign dx_d    = $signed({1'b0, x}) - CX_S;
  assign dy_d    = $signed({1'b0, y}) - CY_S;
  assign dx_sq_s = dx_q * dx_q;
  assign dy_sq_s = dy_q * dy_q;
  assign d2_s    = {1'b0, dx2_q} + {1'b0, dy2_q};
  assign hit_d   = (d2_s >= R_IN2) && (d2_s <= R_OUT2) && gapx_q && gapy_q;

  // Coordinate signs pick the quadrant; zero counts as non-negative
  always_comb begin
    quad_d = Q_B;
    case ({dyn_q, dxn_q})
      2'b00:   quad_d = Q_B;
      2'b01:   quad_d = Q_Y;
      2'b11:   quad_d = Q_R;
      2'b10:   quad_d = Q_G;
      default: quad_d = Q_B;
    endcase
  end

  always_comb begin
    lvl_sel_s = lvl3_q[3:0];
    rgb_d     = 24'h000000;
    case (quad_q)
      Q_B:     lvl_sel_s = lvl3_q[3:0];
      Q_Y:     lvl_sel_s = lvl3_q[7:4];
      Q_R:     lvl_sel_s = lvl3_q[11:8];
      Q_G:     lvl_sel_s = lvl3_q[15:12];
      default: lvl_sel_s = lvl3_q[3:0];
    endcase
    if (!vde3_q) begin
      rgb_d = 24'h000000;
    end else if (hit_q) begin
      rgb_d = scale_rgb(COLOR[quad_q], lvl_sel_s);
    end else begin
      rgb_d = BG_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx_q      <= '0;
      dy_q      <= '0;
      vde1_q    <= 1'b0;
      lvl1_q    <= '0;
      dx2_q     <= '0;
      dy2_q     <= '0;
      dxn_q     <= 1'b0;
      dyn_q     <= 1'b0;
      gapx_q    <= 1'b0;
      gapy_q    <= 1'b0;
      vde2_q    <= 1'b0;
      lvl2_q    <= '0;
      hit_q     <= 1'b0;
      quad_q    <= Q_B;
      vde3_q    <= 1'b0;
      lvl3_q    <= '0;
      rgb_q     <= '0;
      vde_out_q <= 1'b0;
    end else begin
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      vde1_q    <= vde;
      lvl1_q    <= lvl_s;
      dx2_q     <= $unsigned(dx_sq_s);
      dy2_q     <= $unsigned(dy_sq_s);
      dxn_q     <= dx_q[COORD_W];
      dyn_q     <= dy_q[COORD_W];
      gapx_q    <= (dx_q >= GAP_S) || (dx_q <= -GAP_S);
      gapy_q    <= (dy_q >= GAP_S) || (dy_q <= -GAP_S);
      vde2_q    <= vde1_q;
      lvl2_q    <= lvl1_q;
      hit_q     <= hit_d;
      quad_q    <= quad_d;
      vde3_q    <= vde2_q;
      lvl3_q    <= lvl2_q;
      rgb_q     <= rgb_d;
      vde_out_q <= vde3_q;
    end
  end

  assign R       = rgb_q[23:16];
  assign G       = rgb_q[15:8];
  assign B       = rgb_q[7:0];
  assign vde_out = vde_out_q;

endmodule

// File: tb/tb_simon_pixel_pipe.sv
// Randomised and directed bench for simon_pixel_pipe against a plain-arithmetic screen model.
module tb_simon_pixel_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] x, y;
  logic        vde, frame_start;
  logic [3:0]  btn_on;
  logic [7:0]  R, G, B;
  logic        vde_out;

  int n_vec = 0;
  int n_err = 0;
  int mlvl [4];
  logic [24:0] exp_q [$];
  string       tag_q [$];

  simon_pixel_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .x           (x),
    .y           (y),
    .vde         (vde),
    .frame_start (frame_start),
    .btn_on      (btn_on),
    .R           (R),
    .G           (G),
    .B           (B),
    .vde_out     (vde_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [24:0] obs, input logic [24:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got vde=%0b rgb=%06h, want vde=%0b rgb=%06h",
               tag, obs[24], obs[23:0], expv[24], expv[23:0]);
    end
  endtask

  function automatic int scale8(int c, int l);
    return (c * (l + 1)) / 16;
  endfunction

  function automatic logic [24:0] model_px(int xi, int yi, bit v);
    longint dx, dy, d2;
    int q, l;
    int col [4];
    logic [23:0] c;
    col[0] = 24'h0000FF; col[1] = 24'hFFFF00; col[2] = 24'hFF0000; col[3] = 24'h00FF00;
    if (!v) return 25'h0;
    dx = longint'(xi) - 1100;
    dy = longint'(yi) - 562;
    d2 = dx * dx + dy * dy;
    if (!(d2 >= 3600 && d2 <= 90000 && (dx >= 8 || dx <= -8) && (dy >= 8 || dy <= -8)))
      return {1'b1, 24'h101010};
    if (dx >= 0) q = (dy >= 0) ? 0 : 3;
    else         q = (dy >= 0) ? 1 : 2;
    c = col[q][23:0];
    l = mlvl[q];
    return {1'b1, 8'(scale8(int'(c[23:16]), l)), 8'(scale8(int'(c[15:8]), l)),
            8'(scale8(int'(c[7:0]), l))};
  endfunction

  task automatic step(input string tag, input int xi, input int yi, input bit v,
                      input bit fs, input logic [3:0] btn);
    logic [24:0] e;
    string t;
    @(negedge clk);
    if (exp_q.size() == 4) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, {vde_out, R, G, B}, e);
    end
    x = xi[15:0];
    y = yi[15:0];
    vde = v;
    frame_start = fs;
    btn_on = btn;
    if (fs) begin
      for (int i = 0; i < 4; i++) begin
        if (btn[i]) mlvl[i] = 15;
        else if (mlvl[i] > 0) mlvl[i] = mlvl[i] - 1;
      end
    end
    exp_q.push_back(model_px(xi, yi, v));
    tag_q.push_back(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 0, 0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    x = '0; y = '0; vde = 1'b0; frame_start = 1'b0; btn_on = 4'h0;
    for (int i = 0; i < 4; i++) mlvl[i] = 0;
    #1;
    check_eq("reset_out", {vde_out, R, G, B}, 25'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Button B pressed, then released and faded out over 16 frames
    step("press_b", 1200, 662, 1'b1, 1'b1, 4'b0001);
    idle(3);
    for (int f = 0; f < 16; f++) begin
      step("fade_fs", 1200, 662, 1'b1, 1'b1, 4'b0000);
      step("fade_mid", 1200, 662, 1'b1, 1'b0, 4'b0001);
      idle(2);
    end

    // Radius edges and gap with all buttons lit
    step("lit_all", 0, 0, 1'b0, 1'b1, 4'hF);
    step("r_out_in", 1280, 802, 1'b1, 1'b0, 4'h0);
    step("r_out_past", 1281, 802, 1'b1, 1'b0, 4'h0);
    step("r_in_on", 1136, 610, 1'b1, 1'b0, 4'h0);
    step("r_in_past", 1135, 610, 1'b1, 1'b0, 4'h0);
    step("axis_gap", 1400, 562, 1'b1, 1'b0, 4'h0);
    step("diag_212", 1312, 774, 1'b1, 1'b0, 4'h0);
    step("gap_dx5", 1105, 700, 1'b1, 1'b0, 4'h0);
    step("gap_dx8", 1108, 700, 1'b1, 1'b0, 4'h0);
    step("quad_y", 1000, 700, 1'b1, 1'b0, 4'h0);
    step("quad_r", 1000, 450, 1'b1, 1'b0, 4'h0);
    step("quad_g", 1200, 450, 1'b1, 1'b0, 4'h0);
    step("vde_low", 1200, 662, 1'b0, 1'b0, 4'h0);
    step("far_off", 65535, 0, 1'b1, 1'b0, 4'h0);
    step("hit_pre_rst", 1200, 662, 1'b1, 1'b0, 4'h0);
    idle(3);
    step("hit_pre_rst", 1200, 662, 1'b1, 1'b0, 4'h0);
    step("hit_pre_rst", 1000, 450, 1'b1, 1'b0, 4'h0);
    step("hit_pre_rst", 1000, 700, 1'b1, 1'b0, 4'h0);

    // Mid-stream asynchronous reset
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async", {vde_out, R, G, B}, 25'h0);
    exp_q.delete();
    tag_q.delete();
    for (int i = 0; i < 4; i++) mlvl[i] = 0;
    vde = 1'b0; frame_start = 1'b0; btn_on = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    step("dim_after_rst", 1200, 662, 1'b1, 1'b0, 4'hF);
    step("dim_after_rst_y", 1000, 700, 1'b1, 1'b0, 4'hF);
    idle(3);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      int xi, yi;
      bit v, fs;
      if ($urandom_range(0, 4) == 0) begin
        xi = int'($urandom_range(0, 65535));
        yi = int'($urandom_range(0, 65535));
      end else begin
        xi = 1100 + int'($urandom_range(0, 700)) - 350;
        yi = 562 + int'($urandom_range(0, 700)) - 350;
      end
      v  = ($urandom_range(0, 7) != 0);
      fs = ($urandom_range(0, 15) == 0);
      step("rand", xi, yi, v, fs, 4'($urandom_range(0, 15)));
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
